// File: rtl/pmix_code_ctrl_if.sv
// pmix_code_ctrl_if: vote/code bus between the bang-bang phase detector,
// the phase controller and the phase mixer. The master side produces votes
// and hold; the slave side (the controller) returns the mixer code.
interface pmix_code_ctrl_if;
  logic              Up;
  logic              Dn;
  logic              Vote_Valid;
  logic              Hold;
  logic [9:0]        Code;
  logic              Code_Update;
  logic signed [6:0] Freq_Out;

  modport master (
    output Up, Dn, Vote_Valid, Hold,
    input  Code, Code_Update, Freq_Out
  );

  modport slave (
    input  Up, Dn, Vote_Valid, Hold,
    output Code, Code_Update, Freq_Out
  );
endinterface

// File: rtl/pmix_code_ctrl.sv
// pmix_code_ctrl: CDR phase-mixer code controller.
// Filters early/late votes into proportional steps and walks a circular
// phase index P = 255*quadrant + weight (0..1019), never emitting weight 255.
// Optional second-order (frequency) path is built when PMIX_CTRL_FREQ_EN is
// defined; otherwise the loop is first order and Freq_Out reads 0.
module pmix_code_ctrl #(
  parameter int          VOTE_TH    = 4,
  parameter int          STEP       = 8,
  parameter logic [9:0]  INIT_CODE  = 10'h000,
  parameter int          FREQ_SHIFT = 6,
  parameter int          FREQ_MAX   = 7
) (
  input  logic            CLK,
  input  logic            RST,
  pmix_code_ctrl_if.slave bus
);

  localparam logic signed [4:0]  C_TH   = 5'(VOTE_TH);
  localparam logic signed [10:0] C_STEP = 11'(STEP);
  localparam logic signed [10:0] C_TMAX = 11'sd254;

  // Reject parameter sets that would break the phase-index invariants.
  if (VOTE_TH < 1 || VOTE_TH > 15 || STEP < 1 || STEP > 64 ||
      FREQ_MAX < 1 || FREQ_MAX > 64 || FREQ_SHIFT < 1 ||
      INIT_CODE[7:0] == 8'hFF) begin : g_bad_param
    $error("pmix_code_ctrl: parameter out of range");
  end

  logic signed [4:0]  r_v;
  logic [9:0]         r_code;
  logic               r_upd;

  logic signed [4:0]  w_delta;
  logic signed [4:0]  w_v_sum;
  logic signed [4:0]  w_v_next;
  logic signed [10:0] w_s;
  logic signed [10:0] w_fstep;
  logic signed [10:0] w_t_raw;
  logic signed [10:0] w_t;
  logic signed [10:0] w_wsum;
  logic signed [10:0] w_wadj;
  logic [1:0]         w_quad;
  logic [9:0]         w_code_next;

  // Vote filter: net vote count, threshold detection, proportional term.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_delta  = 5'sd0;
    w_s      = 11'sd0;
    if (bus.Vote_Valid && bus.Up && !bus.Dn)      w_delta = 5'sd1;
    else if (bus.Vote_Valid && bus.Dn && !bus.Up) w_delta = -5'sd1;
    w_v_sum  = r_v + w_delta;
    w_v_next = w_v_sum;
    if (w_v_sum == C_TH) begin
      w_s      = C_STEP;
      w_v_next = 5'sd0;
    end else if (w_v_sum == -C_TH) begin
      w_s      = -C_STEP;
      w_v_next = 5'sd0;
    end
  end

`ifdef PMIX_CTRL_FREQ_EN
  localparam logic signed [7:0] C_FMAX = 8'(FREQ_MAX);

  logic signed [7:0]       r_f;
  logic [FREQ_SHIFT-1:0]   r_per;
  logic signed [7:0]       w_f_next;

  // Frequency term fires on the period-counter wrap edge, using the old F.
  always_comb begin
    w_fstep  = (&r_per) ? {{3{r_f[7]}}, r_f} : 11'sd0;
    w_f_next = r_f;
    if (w_s > 0 && r_f < C_FMAX)       w_f_next = r_f + 8'sd1;
    else if (w_s < 0 && r_f > -C_FMAX) w_f_next = r_f - 8'sd1;
  end

  // Frequency integrator and its free-running period counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_f   <= 8'sd0;
      r_per <= '0;
    end else if (!bus.Hold) begin
      r_f   <= w_f_next;
      r_per <= r_per + 1'b1;
    end
  end

  assign bus.Freq_Out = r_f[6:0];
`else
  assign w_fstep      = 11'sd0;
  assign bus.Freq_Out = 7'sd0;
`endif

  // Sum, clamp, and apply the step with carry/borrow through the quadrant.
  always_comb begin
    w_t_raw = w_s + w_fstep;
    w_t     = w_t_raw;
    if (w_t_raw > C_TMAX)       w_t = C_TMAX;
    else if (w_t_raw < -C_TMAX) w_t = -C_TMAX;
    w_wsum = $signed({3'b000, r_code[7:0]}) + w_t;
    w_wadj = w_wsum;
    w_quad = r_code[9:8];
    if (w_wsum >= 11'sd255) begin
      w_wadj = w_wsum - 11'sd255;
      w_quad = r_code[9:8] + 2'd1;
    end else if (w_wsum < 11'sd0) begin
      w_wadj = w_wsum + 11'sd255;
      w_quad = r_code[9:8] - 2'd1;
    end
    w_code_next = {w_quad, w_wadj[7:0]};
  end

  // Vote counter, mixer code and update strobe; Hold freezes all of them.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      r_v    <= 5'sd0;
      r_code <= INIT_CODE;
      r_upd  <= 1'b0;
    end else if (bus.Hold) begin
      r_upd  <= 1'b0;
    end else begin
      r_v    <= w_v_next;
      r_code <= w_code_next;
      r_upd  <= (w_t != 11'sd0);
    end
  end

  assign bus.Code        = r_code;
  assign bus.Code_Update = r_upd;

endmodule

// File: tb/tb_pmix_code_ctrl.sv
// tb_pmix_code_ctrl: directed bench for pmix_code_ctrl. Instance a starts at
// code 0, instance b starts at P=1018 (11_11111101) for the forward wrap.
module tb_pmix_code_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pmix_code_ctrl_if if_a ();
  pmix_code_ctrl_if if_b ();

  pmix_code_ctrl #(.INIT_CODE(10'h000)) u_dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (if_a)
  );

  pmix_code_ctrl #(.INIT_CODE(10'h3FD)) u_dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock on instance a; inputs applied and outputs sampled 1 ns after the edge.
  task automatic tick(input logic v, input logic u, input logic d, input logic h);
    if_a.Vote_Valid = v;
    if_a.Up         = u;
    if_a.Dn         = d;
    if_a.Hold       = h;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic v, input logic u, input logic d);
    if_b.Vote_Valid = v;
    if_b.Up         = u;
    if_b.Dn         = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) tick(0, 0, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h000) begin
      n_errors++; $display("FAIL reset_code: got %h expected %h", if_a.Code, 10'h000);
    end
    n_checks++;
    if (if_a.Code_Update !== 1'b0) begin
      n_errors++; $display("FAIL reset_update: got %b expected 0", if_a.Code_Update);
    end
    n_checks++;
    if (if_a.Freq_Out !== 7'sd0) begin
      n_errors++; $display("FAIL reset_freq: got %0d expected 0", if_a.Freq_Out);
    end
    n_checks++;
    if (if_b.Code !== 10'h3FD) begin
      n_errors++; $display("FAIL reset_init_code_b: got %h expected %h", if_b.Code, 10'h3FD);
    end
  endtask

  task automatic test_prop_up();
    logic bad;
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0);
      if (if_a.Code !== 10'h000 || if_a.Code_Update !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL prop_below_threshold: code %h upd %b expected 000/0", if_a.Code, if_a.Code_Update);
    end
    tick(1, 1, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h008 || if_a.Code_Update !== 1'b1) begin
      n_errors++; $display("FAIL prop_step: code %h upd %b expected 008/1", if_a.Code, if_a.Code_Update);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h008 || if_a.Code_Update !== 1'b0) begin
      n_errors++; $display("FAIL prop_update_pulse: code %h upd %b expected 008/0", if_a.Code, if_a.Code_Update);
    end
    // V must have cleared: three more votes do not step, the fourth does.
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0);
      if (if_a.Code !== 10'h008) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL prop_v_cleared: code %h expected 008", if_a.Code);
    end
    tick(1, 1, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h010) begin
      n_errors++; $display("FAIL prop_second_step: got %h expected 010", if_a.Code);
    end
  endtask

  task automatic test_forward_wrap();
    logic saw_255;
    saw_255 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_b(1, 1, 0);
      if (if_b.Code[7:0] === 8'hFF) saw_255 = 1'b1;
    end
    n_checks++;
    if (if_b.Code !== 10'h006 || if_b.Code_Update !== 1'b1) begin
      n_errors++; $display("FAIL fwd_wrap: code %h upd %b expected 006/1", if_b.Code, if_b.Code_Update);
    end
    n_checks++;
    if (saw_255) begin
      n_errors++; $display("FAIL fwd_wrap_weight255: weight FF observed, expected never");
    end
    tick_b(0, 0, 0);
  endtask

  task automatic test_backward_wrap();
    logic bad;
    do_reset();
    repeat (4) tick(1, 0, 1, 0);
    // 0 - 8: weight -8 borrows to 247 in quadrant 3 (P=1012).
    n_checks++;
    if (if_a.Code !== 10'h3F7 || if_a.Code_Update !== 1'b1) begin
      n_errors++; $display("FAIL bwd_wrap: code %h upd %b expected 3f7/1", if_a.Code, if_a.Code_Update);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 1, 0);
      if (if_a.Code !== 10'h3F7 || if_a.Code_Update !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL cancel_votes: code %h upd %b expected 3f7/0", if_a.Code, if_a.Code_Update);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, 0);
      if (if_a.Code !== 10'h3F7) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL invalid_votes: code %h expected 3f7", if_a.Code);
    end
    repeat (4) tick(1, 0, 1, 0);
    n_checks++;
    if (if_a.Code !== 10'h3EF) begin
      n_errors++; $display("FAIL bwd_second_step: got %h expected 3ef", if_a.Code);
    end
  endtask

  task automatic test_hold_reset();
    logic bad;
    do_reset();
    repeat (3) tick(1, 1, 0, 0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0, 1);
      if (if_a.Code !== 10'h000 || if_a.Code_Update !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL hold_frozen: code %h upd %b expected 000/0", if_a.Code, if_a.Code_Update);
    end
    tick(1, 1, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h008 || if_a.Code_Update !== 1'b1) begin
      n_errors++; $display("FAIL hold_resume: code %h upd %b expected 008/1", if_a.Code, if_a.Code_Update);
    end
    repeat (3) tick(1, 1, 0, 0);
    rst = 1'b1;
    tick(0, 0, 0, 0);
    rst = 1'b0;
    n_checks++;
    if (if_a.Code !== 10'h000 || if_a.Code_Update !== 1'b0) begin
      n_errors++; $display("FAIL midcount_reset: code %h upd %b expected 000/0", if_a.Code, if_a.Code_Update);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0);
      if (if_a.Code !== 10'h000) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL reset_clears_v: code %h expected 000", if_a.Code);
    end
    tick(1, 1, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h008) begin
      n_errors++; $display("FAIL post_reset_step: got %h expected 008", if_a.Code);
    end
    // Reset wins over Hold.
    rst = 1'b1;
    tick(0, 0, 0, 1);
    rst = 1'b0;
    n_checks++;
    if (if_a.Code !== 10'h000) begin
      n_errors++; $display("FAIL reset_over_hold: got %h expected 000", if_a.Code);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_freq();
    int n_upd;
    do_reset();
    repeat (16) tick(1, 1, 0, 0);
    n_checks++;
    if (if_a.Code !== 10'h020) begin
      n_errors++; $display("FAIL freq_prop_steps: got %h expected 020", if_a.Code);
    end
`ifdef PMIX_CTRL_FREQ_EN
    n_checks++;
    if (if_a.Freq_Out !== 7'sd4) begin
      n_errors++; $display("FAIL freq_value: got %0d expected 4", if_a.Freq_Out);
    end
    n_upd = 0;
    for (int i = 0; i < 64; i++) begin
      tick(0, 0, 0, 0);
      if (if_a.Code_Update === 1'b1) n_upd++;
    end
    n_checks++;
    if (if_a.Code !== 10'h024 || n_upd != 1) begin
      n_errors++; $display("FAIL freq_idle_advance: code %h updates %0d expected 024/1", if_a.Code, n_upd);
    end
    repeat (160) tick(1, 1, 0, 0);
    n_checks++;
    if (if_a.Freq_Out !== 7'sd7) begin
      n_errors++; $display("FAIL freq_saturate: got %0d expected 7", if_a.Freq_Out);
    end
`else
    n_checks++;
    if (if_a.Freq_Out !== 7'sd0) begin
      n_errors++; $display("FAIL freq_tied_zero: got %0d expected 0", if_a.Freq_Out);
    end
    n_upd = 0;
    for (int i = 0; i < 130; i++) begin
      tick(0, 0, 0, 0);
      if (if_a.Code_Update === 1'b1) n_upd++;
    end
    n_checks++;
    if (if_a.Code !== 10'h020 || n_upd != 0) begin
      n_errors++; $display("FAIL first_order_idle: code %h updates %0d expected 020/0", if_a.Code, n_upd);
    end
`endif
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    if_a.Up         = 1'b0;
    if_a.Dn         = 1'b0;
    if_a.Vote_Valid = 1'b0;
    if_a.Hold       = 1'b0;
    if_b.Up         = 1'b0;
    if_b.Dn         = 1'b0;
    if_b.Vote_Valid = 1'b0;
    if_b.Hold       = 1'b0;
    test_reset();
    test_forward_wrap();
    test_prop_up();
    test_backward_wrap();
    test_hold_reset();
    test_freq();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
